// File: rtl/vga_sync_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_receiver_if
//  Description : Signal bundle between a VGA sync source and the sync
//                receiver: active-low HS/VS strobes in, reconstructed raster
//                position, lock status and measurements out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_receiver_if;
    logic       iVGA_HS;
    logic       iVGA_VS;
    logic [9:0] oX;
    logic [9:0] oY;
    logic       oActive;
    logic       oLocked;
    logic       oFrameStart;
    logic [9:0] oLineLen;
    logic [9:0] oFrameLen;
    logic       oErr;

    // Sync source side: drives the strobes, observes the receiver.
    modport master (
        output iVGA_HS, iVGA_VS,
        input  oX, oY, oActive, oLocked, oFrameStart, oLineLen, oFrameLen, oErr
    );

    // Receiver side.
    modport slave (
        input  iVGA_HS, iVGA_VS,
        output oX, oY, oActive, oLocked, oFrameStart, oLineLen, oFrameLen, oErr
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_receiver
//  Description : Samples active-low HS/VS on the pixel clock, rebuilds the
//                raster position, measures line/frame lengths and reports
//                lock to the nominal raster.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_BACK      = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_BACK      = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               iclk,
    input  logic               irst,
    vga_sync_receiver_if.slave vga
);
    localparam logic [9:0] CNT_MAX    = 10'h3FF;
    localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [9:0] H_BACK_C   = 10'(H_BACK);
    localparam logic [9:0] H_END_C    = 10'(H_BACK + H_ACTIVE);
    localparam logic [9:0] V_BACK_C   = 10'(V_BACK);
    localparam logic [9:0] V_END_C    = 10'(V_BACK + V_ACTIVE);
    localparam logic [3:0] LOCK_C     = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    // Bit 0 is the synchroniser flop, bit 1 the sample being processed,
    // bit 2 the previous sample for edge detection.
    logic [2:0] hs_sync_q, hs_sync_d;
    logic [2:0] vs_sync_q, vs_sync_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       pend_q, pend_d;
    logic       seen_hs_q, seen_hs_d;
    logic       frame_bad_q, frame_bad_d;
    logic [3:0] good_q, good_d;
    state_t     state_q, state_d;
    logic       err_q, err_d;
    logic [9:0] ox_q, ox_d;
    logic [9:0] oy_q, oy_d;
    logic       active_q, active_d;
    logic       locked_q, locked_d;
    logic       fstart_q, fstart_d;
    logic [9:0] line_len_q, line_len_d;
    logic [9:0] frame_len_q, frame_len_d;

    logic       hs_fall;
    logic       vs_fall;
    logic       frame_start;
    logic       line_bad;
    logic       frame_len_bad;
    logic       frame_eval_bad;
    logic [9:0] line_len_new;
    logic [9:0] frame_len_new;

    // Edge detection and per-edge qualification of the measured lengths.
    assign hs_fall        = hs_sync_q[2] & ~hs_sync_q[1];
    assign vs_fall        = vs_sync_q[2] & ~vs_sync_q[1];
    assign frame_start    = hs_fall & (pend_q | vs_fall);
    assign line_len_new   = sat_inc(hcnt_q);
    assign frame_len_new  = sat_inc(vcnt_q);
    // The line ending at the first HS fall after reset is partial, so skip it.
    assign line_bad       = hs_fall & seen_hs_q & (line_len_new != H_TOTAL_C);
    assign frame_len_bad  = (frame_len_new != V_TOTAL_C);
    assign frame_eval_bad = frame_bad_q | line_bad | frame_len_bad;

    // Raster counters, pending-VS flag and length measurements.
    always_comb begin
        hs_sync_d   = {hs_sync_q[1:0], vga.iVGA_HS};
        vs_sync_d   = {vs_sync_q[1:0], vga.iVGA_VS};
        hcnt_d      = sat_inc(hcnt_q);
        vcnt_d      = vcnt_q;
        pend_d      = pend_q | vs_fall;
        seen_hs_d   = seen_hs_q | hs_fall;
        frame_bad_d = frame_bad_q | line_bad;
        line_len_d  = line_len_q;
        frame_len_d = frame_len_q;
        if (hs_fall) begin
            hcnt_d     = '0;
            line_len_d = line_len_new;
            vcnt_d     = sat_inc(vcnt_q);
        end
        if (frame_start) begin
            vcnt_d      = '0;
            pend_d      = 1'b0;
            frame_len_d = frame_len_new;
            frame_bad_d = 1'b0;
        end
    end

    // Lock state machine: acquire, qualify LOCK_FRAMES clean frames, monitor.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;
        case (state_q)
            SEARCH: begin
                if (frame_start) begin
                    state_d = VERIFY;
                    good_d  = '0;
                end
            end
            VERIFY: begin
                if (frame_start) begin
                    if (frame_eval_bad) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                // A bad line drops lock immediately rather than at frame end.
                if (line_bad || (frame_start && frame_len_bad)) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Output stage, computed from the post-update counters and state.
    always_comb begin
        locked_d = (state_d == LOCKED);
        active_d = locked_d
                 & (hcnt_d >= H_BACK_C) & (hcnt_d < H_END_C)
                 & (vcnt_d >= V_BACK_C) & (vcnt_d < V_END_C);
        ox_d     = active_d ? (hcnt_d - H_BACK_C) : '0;
        oy_d     = active_d ? (vcnt_d - V_BACK_C) : '0;
        fstart_d = frame_start;
    end

    // State and output registers.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            hs_sync_q   <= '0;
            vs_sync_q   <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            pend_q      <= 1'b0;
            seen_hs_q   <= 1'b0;
            frame_bad_q <= 1'b0;
            good_q      <= '0;
            state_q     <= SEARCH;
            err_q       <= 1'b0;
            ox_q        <= '0;
            oy_q        <= '0;
            active_q    <= 1'b0;
            locked_q    <= 1'b0;
            fstart_q    <= 1'b0;
            line_len_q  <= '0;
            frame_len_q <= '0;
        end else begin
            hs_sync_q   <= hs_sync_d;
            vs_sync_q   <= vs_sync_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            pend_q      <= pend_d;
            seen_hs_q   <= seen_hs_d;
            frame_bad_q <= frame_bad_d;
            good_q      <= good_d;
            state_q     <= state_d;
            err_q       <= err_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            active_q    <= active_d;
            locked_q    <= locked_d;
            fstart_q    <= fstart_d;
            line_len_q  <= line_len_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign vga.oX          = ox_q;
    assign vga.oY          = oy_q;
    assign vga.oActive     = active_q;
    assign vga.oLocked     = locked_q;
    assign vga.oFrameStart = fstart_q;
    assign vga.oLineLen    = line_len_q;
    assign vga.oFrameLen   = frame_len_q;
    assign vga.oErr        = err_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_receiver
//  Description : Self-checking bench for vga_sync_receiver on a reduced
//                raster; randomized sync streams against a sample-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_receiver;
    // Reduced raster so that many frames fit in a short run.
    localparam int HT  = 32;
    localparam int VT  = 10;
    localparam int HB  = 8;
    localparam int HA  = 20;
    localparam int VB  = 2;
    localparam int VA  = 6;
    localparam int LF  = 2;
    localparam int HSW = 5;

    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic iclk = 1'b0;
    logic irst;

    vga_sync_receiver_if vga ();

    vga_sync_receiver #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .H_BACK      (HB),
        .H_ACTIVE    (HA),
        .V_BACK      (VB),
        .V_ACTIVE    (VA),
        .LOCK_FRAMES (LF)
    ) dut (
        .iclk (iclk),
        .irst (irst),
        .vga  (vga)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_h, m_v, m_mode, m_good;
    bit m_pend, m_seen, m_fbad, m_err, m_prev_hs, m_prev_vs;
    int e_x, e_y, e_ll, e_fl;
    bit e_act, e_lock, e_fs;

    logic q_hs[$];
    logic q_vs[$];
    int   n_samples = 0;
    int   reset_at  = -1;
    int   next_voff = 0;
    int   fs_since  = 0;
    bit   was_locked = 1'b0;
    bit   count_en   = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode = M_SEARCH; m_good = 0;
        m_pend = 0; m_seen = 0; m_fbad = 0; m_err = 0;
        m_prev_hs = 0; m_prev_vs = 0;
        e_x = 0; e_y = 0; e_ll = 0; e_fl = 0;
        e_act = 0; e_lock = 0; e_fs = 0;
    endtask

    // One processed sync sample, straight from the receiver's rules.
    task automatic model_step(input logic hs, input logic vs);
        bit hf, vf, bad_line, bad_len;
        int len, flen;
        hf = m_prev_hs && !hs;
        vf = m_prev_vs && !vs;
        m_prev_hs = hs;
        m_prev_vs = vs;
        e_fs = 0;
        if (vf) m_pend = 1;
        if (hf) begin
            len      = sat(m_h + 1);
            e_ll     = len;
            m_h      = 0;
            bad_line = m_seen && (len != HT);
            m_seen   = 1;
            if (m_pend) begin
                flen    = sat(m_v + 1);
                e_fl    = flen;
                m_v     = 0;
                m_pend  = 0;
                e_fs    = 1;
                bad_len = (flen != VT);
                if (m_mode == M_SEARCH) begin
                    m_mode = M_VERIFY;
                    m_good = 0;
                end else if (m_mode == M_VERIFY) begin
                    if (m_fbad || bad_line || bad_len) m_good = 0;
                    else m_good = m_good + 1;
                    if (m_good == LF) m_mode = M_LOCKED;
                end else if (bad_line || bad_len) begin
                    m_mode = M_SEARCH;
                    m_err  = 1;
                end
                m_fbad = 0;
            end else begin
                m_v = sat(m_v + 1);
                if (bad_line) m_fbad = 1;
                if (m_mode == M_LOCKED && bad_line) begin
                    m_mode = M_SEARCH;
                    m_err  = 1;
                end
            end
        end else begin
            m_h = sat(m_h + 1);
        end
        e_lock = (m_mode == M_LOCKED);
        e_act  = e_lock && m_h >= HB && m_h < HB + HA && m_v >= VB && m_v < VB + VA;
        e_x    = e_act ? m_h - HB : 0;
        e_y    = e_act ? m_v - VB : 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_oX"},         32'(vga.oX),          0);
        check({tag, "_oY"},         32'(vga.oY),          0);
        check({tag, "_oActive"},    32'(vga.oActive),     0);
        check({tag, "_oLocked"},    32'(vga.oLocked),     0);
        check({tag, "_oFrameStart"},32'(vga.oFrameStart), 0);
        check({tag, "_oLineLen"},   32'(vga.oLineLen),    0);
        check({tag, "_oFrameLen"},  32'(vga.oFrameLen),   0);
        check({tag, "_oErr"},       32'(vga.oErr),        0);
    endtask

    // Called at posedge+1 with irst high: release mid-cycle and re-seed model.
    task automatic release_reset();
        #1 irst = 1'b0;
        model_reset();
        q_hs.delete();
        q_vs.delete();
        q_hs.push_back(1'b0); q_vs.push_back(1'b0);
        q_hs.push_back(1'b0); q_vs.push_back(1'b0);
        q_hs.push_back(vga.iVGA_HS); q_vs.push_back(vga.iVGA_VS);
        fs_since   = 0;
        was_locked = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        #2 irst = 1'b1;
        #1 check_all_zero("async_rst");
        repeat (cycles) @(posedge iclk);
        #1 check_all_zero("in_rst");
        release_reset();
    endtask

    // Counts frame starts from the last lock loss (or reset) to the lock rise.
    task automatic track_lock();
        if (vga.oFrameStart) fs_since++;
        if (vga.oLocked && !was_locked && count_en)
            check("fs_to_lock", fs_since, LF + 1);
        if (!vga.oLocked && was_locked) fs_since = 0;
        was_locked = vga.oLocked;
    endtask

    task automatic step(input logic hs, input logic vs);
        logic ph, pv;
        @(posedge iclk);
        #1;
        ph = q_hs.pop_front();
        pv = q_vs.pop_front();
        model_step(ph, pv);
        check("oX",          32'(vga.oX),          e_x);
        check("oY",          32'(vga.oY),          e_y);
        check("oActive",     32'(vga.oActive),     32'(e_act));
        check("oLocked",     32'(vga.oLocked),     32'(e_lock));
        check("oFrameStart", 32'(vga.oFrameStart), 32'(e_fs));
        check("oLineLen",    32'(vga.oLineLen),    e_ll);
        check("oFrameLen",   32'(vga.oFrameLen),   e_fl);
        check("oErr",        32'(vga.oErr),        32'(m_err));
        track_lock();
        vga.iVGA_HS = hs;
        vga.iVGA_VS = vs;
        q_hs.push_back(hs);
        q_vs.push_back(vs);
        n_samples++;
        if (n_samples == reset_at) do_reset($urandom_range(1, 3));
    endtask

    // One frame; VS falls next_voff samples before the following frame start
    // (0 = on the same sample as the frame-start HS fall).
    task automatic send_frame(input int nlines, input int bad_line, input int bad_len, input bit vs_en);
        int cur, flen, s, len;
        logic hs_v, vs_v;
        cur       = next_voff;
        next_voff = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, HT - 1));
        flen = 0;
        for (int l = 0; l < nlines; l++) flen += (l == bad_line) ? bad_len : HT;
        s = 0;
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : HT;
            for (int p = 0; p < len; p++) begin
                hs_v = (p >= HSW);
                vs_v = !(vs_en && ((s < 2 * HT - cur) || (s >= flen - next_voff)));
                step(hs_v, vs_v);
                s++;
            end
        end
    endtask

    task automatic clean_frames(input int n);
        repeat (n) send_frame(VT, -1, HT, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        irst        = 1'b1;
        vga.iVGA_HS = 1'b1;
        vga.iVGA_VS = 1'b1;
        model_reset();
        repeat (3) @(posedge iclk);
        #1 check_all_zero("por");
        release_reset();

        // Clean stream from a random phase: lock at the third frame start.
        repeat ($urandom_range(0, 40)) step(1'b1, 1'b1);
        clean_frames(5);
        check("clean_locked",  32'(vga.oLocked),   1);
        check("clean_err",     32'(vga.oErr),      0);
        check("clean_linelen", 32'(vga.oLineLen),  HT);
        check("clean_framelen",32'(vga.oFrameLen), VT);

        // One stretched line while locked.
        send_frame(VT, $urandom_range(0, VT - 1), HT + 1, 1'b1);
        clean_frames(4);
        check("stretch_relock", 32'(vga.oLocked), 1);
        check("stretch_err",    32'(vga.oErr),    1);

        // HS stuck high long enough to saturate the line counter.
        repeat (1500) step(1'b1, 1'b1);
        clean_frames(5);

        // Bad line during verification delays lock.
        count_en = 1'b0;
        do_reset(2);
        clean_frames(2);
        send_frame(VT, 3, HT - 1, 1'b1);
        clean_frames(5);
        check("verify_relock", 32'(vga.oLocked), 1);
        count_en = 1'b1;

        // VS missing long enough to saturate the line count.
        repeat (110) send_frame(VT, -1, HT, 1'b0);
        clean_frames(5);

        // Asynchronous reset in the middle of a locked frame.
        reset_at = n_samples + int'($urandom_range(100, 600));
        clean_frames(9);
        check("final_locked", 32'(vga.oLocked), 1);
        check("final_err",    32'(vga.oErr),    0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
